multiplier: RTL and testbench

- Sequential shift-add unsigned fixed-point multiplier. It is the inverse-operation companion to the team's 10-bit divider and uses the same start/busy/valid/ovf handshake, so both can sit behind one arithmetic-unit controller.
- Computes p = (a*b) >> FRAC, truncated to WIDTH bits, processing one multiplier bit per clock.
- Flags overflow (ovf) and a zero product (zro).

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_data_path.sv | 94 +++++++++
 rtl/multiplier_controller.sv | 74 +++++++
 rtl/multiplier.sv | 60 ++++++
 tb/tb_multiplier.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add fixed-point multiplier.
package mult_pkg;

  localparam int unsigned DEF_WIDTH = 10;
  localparam int unsigned DEF_FRAC  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_data_path.sv
// Operand, accumulator, counter and result registers for the shift-add multiplier.
module mult_data_path
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             load,
  input  logic             add_en,
  input  logic             shift,
  input  logic             cnt_en,
  input  logic             out_load,
  output logic             zero_in,
  output logic             cnt_done,
  output logic [WIDTH-1:0] p_out,
  output logic             ovf,
  output logic             zro
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH:0]     acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] f_nx;
  logic [WIDTH-1:0]   p_nx;

  assign addend   = (add_en && q_q[0]) ? {1'b0, a_q} : '0;
  assign sum      = acc_q + addend;
  // Full product as it will stand after this edge's add and shift.
  assign f_nx     = {sum, q_q[WIDTH-1:1]};
  assign p_nx     = WIDTH'(f_nx >> FRAC);
  assign zero_in  = (a_in == '0) || (b_in == '0);
  assign cnt_done = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (sclr) begin
      a_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= a_in;
      q_q   <= b_in;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (shift) begin
        acc_q <= {1'b0, sum[WIDTH:1]};
        q_q   <= {sum[0], q_q[WIDTH-1:1]};
      end
      if (cnt_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Result registers hold until the next out_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_out <= '0;
      ovf   <= 1'b0;
      zro   <= 1'b0;
    end else if (sclr) begin
      p_out <= '0;
      ovf   <= 1'b0;
      zro   <= 1'b0;
    end else if (out_load) begin
      if (load) begin
        p_out <= '0;
        ovf   <= 1'b0;
        zro   <= 1'b1;
      end else begin
        p_out <= p_nx;
        ovf   <= |(f_nx >> (FRAC + WIDTH));
        zro   <= (p_nx == '0);
      end
    end
  end

endmodule

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the shift-add multiplier; mirrors the divider handshake.
module multiplier_controller
  import mult_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sclr,
  input  logic start,
  input  logic zero_in,
  input  logic cnt_done,
  output logic load,
  output logic add_en,
  output logic shift,
  output logic cnt_en,
  output logic out_load,
  output logic busy,
  output logic valid
);

  state_t state, state_nx;

  // State register; busy/valid are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else if (sclr) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == CALC);
      valid <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    add_en   = 1'b0;
    shift    = 1'b0;
    cnt_en   = 1'b0;
    out_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load = 1'b1;
          // A zero operand short-circuits straight to a zero result.
          if (zero_in) begin
            out_load = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = CALC;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        add_en = 1'b1;
        shift  = 1'b1;
        cnt_en = !cnt_done;
        if (cnt_done) begin
          out_load = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned fixed-point multiplier: p = (a*b) >> FRAC, one bit per clock.
module multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] p_out,
  output logic             ovf,
  output logic             zro,
  output logic             busy,
  output logic             valid
);

  logic load, add_en, shift, cnt_en, out_load, zero_in, cnt_done;

  multiplier_controller u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclr     (sclr),
    .start    (start),
    .zero_in  (zero_in),
    .cnt_done (cnt_done),
    .load     (load),
    .add_en   (add_en),
    .shift    (shift),
    .cnt_en   (cnt_en),
    .out_load (out_load),
    .busy     (busy),
    .valid    (valid)
  );

  mult_data_path #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclr     (sclr),
    .a_in     (a_in),
    .b_in     (b_in),
    .load     (load),
    .add_en   (add_en),
    .shift    (shift),
    .cnt_en   (cnt_en),
    .out_load (out_load),
    .zero_in  (zero_in),
    .cnt_done (cnt_done),
    .p_out    (p_out),
    .ovf      (ovf),
    .zro      (zro)
  );

endmodule

// File: tb/tb_multiplier.sv
// Directed scoreboard bench for the multiplier: integer (FRAC=0) and fixed-point (FRAC=5) instances.
module tb_multiplier;

  localparam int unsigned W = 10;

  typedef struct packed {
    logic [W-1:0] p;
    logic         ovf;
    logic         zro;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, sclr;
  logic         start0, start5;
  logic [W-1:0] a0, b0, a5, b5;
  logic [W-1:0] p0, p5;
  logic         ovf0, zro0, busy0, valid0;
  logic         ovf5, zro5, busy5, valid5;

  exp_t q0[$];
  exp_t q5[$];
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  multiplier #(.WIDTH(W), .FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start0), .a_in(a0), .b_in(b0),
    .p_out(p0), .ovf(ovf0), .zro(zro0), .busy(busy0), .valid(valid0)
  );

  multiplier #(.WIDTH(W), .FRAC(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start5), .a_in(a5), .b_in(b5),
    .p_out(p5), .ovf(ovf5), .zro(zro5), .busy(busy5), .valid(valid5)
  );

  function automatic exp_t model(input int a, input int b, input int frac);
    logic [63:0] full;
    logic [63:0] s;
    exp_t r;
    full  = 64'(a) * 64'(b);
    s     = full >> frac;
    r.p   = W'(s);
    r.ovf = ((s >> W) != 64'd0);
    r.zro = (r.p == '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit sel, input int a, input int b);
    if (sel) begin
      start5 = 1'b1; a5 = W'(a); b5 = W'(b);
    end else begin
      start0 = 1'b1; a0 = W'(a); b0 = W'(b);
    end
    tick();
    start0 = 1'b0;
    start5 = 1'b0;
  endtask

  task automatic push(input bit sel, input int a, input int b);
    if (sel) q5.push_back(model(a, b, 5));
    else     q0.push_back(model(a, b, 0));
  endtask

  // Wait (bounded) for valid, then compare latency, busy length and result against the queue head.
  task automatic wait_result(input string tag, input bit sel, input int exp_lat, input int exp_busy);
    int   lat;
    int   nb;
    exp_t e;
    lat = 0;
    nb  = 0;
    while (!(sel ? valid5 : valid0) && lat < 20) begin
      if (sel ? busy5 : busy0) nb++;
      tick();
      lat++;
    end
    check({tag, "_valid"}, 32'(sel ? valid5 : valid0), 32'd1);
    check({tag, "_lat"}, 32'(lat + 1), 32'(exp_lat));
    check({tag, "_busy"}, 32'(nb), 32'(exp_busy));
    if ((sel ? q5.size() : q0.size()) == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sel ? q5.pop_front() : q0.pop_front();
      check({tag, "_p"}, 32'(sel ? p5 : p0), 32'(e.p));
      check({tag, "_ovf"}, 32'(sel ? ovf5 : ovf0), 32'(e.ovf));
      check({tag, "_zro"}, 32'(sel ? zro5 : zro0), 32'(e.zro));
    end
  endtask

  task automatic expect_no_valid(input string tag, input int cycles);
    int nv;
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      if (valid0) nv++;
      tick();
    end
    check(tag, 32'(nv), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    sclr   = 1'b0;
    start0 = 1'b0;
    start5 = 1'b0;
    a0 = '0; b0 = '0; a5 = '0; b5 = '0;
    #12;
    check("rst_p", 32'(p0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_zro", 32'(zro0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic product, then valid must drop after one cycle.
    start_op(0, 25, 13); push(0, 25, 13);
    wait_result("m25x13", 0, 11, 10);
    tick();
    check("m25x13_pulse", 32'(valid0), 32'd0);

    start_op(0, 1023, 1023); push(0, 1023, 1023);
    wait_result("m1023sq", 0, 11, 10);
    tick();

    // Zero operands finish in one cycle without busy.
    start_op(0, 0, 700); push(0, 0, 700);
    wait_result("z0x700", 0, 1, 0);
    tick();
    start_op(0, 700, 0); push(0, 700, 0);
    wait_result("z700x0", 0, 1, 0);
    tick();

    // Start during CALC is ignored; start during DONE is accepted.
    start_op(0, 25, 13); push(0, 25, 13);
    tick();
    tick();
    start_op(0, 3, 3);
    wait_result("ign", 0, 8, 7);
    start_op(0, 3, 3); push(0, 3, 3);
    wait_result("b2b", 0, 11, 10);
    tick();
    check("b2b_pulse", 32'(valid0), 32'd0);

    // Asynchronous reset mid-operation.
    start_op(0, 25, 13);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_valid", 32'(valid0), 32'd0);
    check("arst_p", 32'(p0), 32'd0);
    rst_n = 1'b1;
    expect_no_valid("arst_novalid", 15);

    // Synchronous clear mid-operation, then clear beats start.
    start_op(0, 25, 13);
    tick();
    check("sclr_pre_busy", 32'(busy0), 32'd1);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    check("sclr_busy", 32'(busy0), 32'd0);
    check("sclr_valid", 32'(valid0), 32'd0);
    sclr = 1'b1; start0 = 1'b1; a0 = W'(5); b0 = W'(5);
    tick();
    sclr = 1'b0; start0 = 1'b0;
    check("sclr_start_busy", 32'(busy0), 32'd0);
    expect_no_valid("sclr_novalid", 15);

    // Operation still works after the clears.
    start_op(0, 31, 33); push(0, 31, 33);
    wait_result("post_clr", 0, 11, 10);
    tick();

    // Fixed-point instance.
    start_op(1, 96, 80); push(1, 96, 80);
    wait_result("f96x80", 1, 11, 10);
    tick();
    start_op(1, 1023, 64); push(1, 1023, 64);
    wait_result("f1023x64", 1, 11, 10);
    tick();
    start_op(1, 1, 1); push(1, 1, 1);
    wait_result("ftrunc0", 1, 11, 10);
    tick();

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q5_empty", 32'(q5.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
